// File: rtl/clock_gated_seq_div_16by8.sv
// Clock-gated sequential restoring divider, one quotient bit per gated clock.
// The lowest APPROX_K quotient iterations are skipped for an approximate result.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          clock-gate enable; low freezes all state and outputs
//   start       request a new division (sampled on a gated edge)
//   dividend    numerator, captured on an accepted start
//   divisor     denominator, captured on an accepted start
//   quotient    result quotient (low APPROX_K bits are 0)
//   remainder   result remainder
//   busy        division in progress
//   done        result valid, held until the next accepted start
//   div_by_zero last accepted operation had divisor == 0
module clock_gated_seq_div_16by8 #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8,
  parameter int unsigned APPROX_K   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int unsigned ITER  = DIVIDEND_W - APPROX_K;
  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);
  localparam int unsigned DIF_W = DIVISOR_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ICG: enable latched while clk is low so gclk cannot glitch
  logic en_lat;
  logic gclk;

  always_latch begin
    if (!clk) en_lat = en;
  end

  assign gclk = clk & en_lat;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dq;     // dividend bits shift out the top, quotient bits in the bottom
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W-1:0]  prem;   // partial remainder, always < divisor between iterations

  // One restoring iteration: bring in the next dividend bit and trial-subtract
  logic [DIVISOR_W:0]    trial;
  logic [DIF_W-1:0]      diff;
  logic                  ge;
  logic [DIVISOR_W-1:0]  prem_nxt;
  logic [DIVIDEND_W-1:0] dq_nxt;

  always_comb begin
    trial    = {prem, dq[DIVIDEND_W-1]};
    diff     = DIF_W'({1'b0, trial}) - DIF_W'(dvs);
    ge       = ~diff[DIF_W-1];
    prem_nxt = ge ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
    dq_nxt   = {dq[DIVIDEND_W-2:0], ge};
  end

  // Control and datapath; every flop runs on the gated clock
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dq          <= '0;
      dvs         <= '0;
      prem        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[DIVISOR_W-1:0];
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= DONE;
            end else begin
              dq          <= dividend;
              dvs         <= divisor;
              prem        <= '0;
              cnt         <= CNT_W'(ITER);
              busy        <= 1'b1;
              done        <= 1'b0;
              div_by_zero <= 1'b0;
              state       <= RUN;
            end
          end
        end

        RUN: begin
          dq   <= dq_nxt;
          prem <= prem_nxt;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            // Low ITER bits hold the computed quotient; skipped bits read as 0
            quotient  <= DIVIDEND_W'(dq_nxt << APPROX_K);
            remainder <= prem_nxt;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_gated_seq_div_16by8.sv
module tb_clock_gated_seq_div_16by8;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;

  logic [15:0] q0, q4;
  logic [7:0]  r0, r4;
  logic        b0, b4, d0, d4, z0, z4;

  int total = 0;
  int bad   = 0;

  clock_gated_seq_div_16by8 #(.DIVIDEND_W(16), .DIVISOR_W(8), .APPROX_K(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(q0), .remainder(r0), .busy(b0), .done(d0), .div_by_zero(z0)
  );

  clock_gated_seq_div_16by8 #(.DIVIDEND_W(16), .DIVISOR_W(8), .APPROX_K(4)) u_dut_k4 (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(q4), .remainder(r4), .busy(b4), .done(d4), .div_by_zero(z4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: divide the truncated dividend, then restore the scale
  function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [7:0] b, input int k);
    int unsigned t;
    if (b == 8'd0) return 16'hFFFF;
    t = 32'(a) >> k;
    return 16'((t / 32'(b)) << k);
  endfunction

  function automatic logic [7:0] ref_r(input logic [15:0] a, input logic [7:0] b, input int k);
    int unsigned t;
    if (b == 8'd0) return a[7:0];
    t = 32'(a) >> k;
    return 8'(t % 32'(b));
  endfunction

  // Negedge index (accept edge = 1) at which done is first observed
  function automatic int ref_lat(input int iter, input logic [7:0] b, input int gap_at, input int gap_len);
    if (b == 8'd0) return 1;
    if (gap_len == 0 || iter + 1 <= gap_at) return iter + 1;
    return iter + 1 + gap_len;
  endfunction

  // One division: optional en gap and optional ignored start pulse mid-run
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        input int gap_at, input int gap_len, input int ign_at);
    int e;
    int e4;
    logic [15:0] q_prev;
    logic [7:0]  r_prev;
    q_prev = q0;
    r_prev = r0;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
    e = 1;
    check("accept_busy", 32'(b0), 32'(b != 8'd0));
    check("accept_done", 32'(d0), 32'(b == 8'd0));
    e4 = d4 ? 1 : 0;
    while (!d0 && e < 200) begin
      check("run_busy", 32'(b0), 32'd1);
      check("run_q_hold", {q0, r0}, {q_prev, r_prev});
      @(negedge clk);
      e++;
      if (e4 == 0 && d4) e4 = e;
      if (e == ign_at) begin
        start    = 1'b1;
        dividend = 16'd200;
        divisor  = 8'd3;
      end else if (e == ign_at + 1) begin
        start = 1'b0;
      end
      if (gap_len != 0 && e == gap_at) en = 1'b0;
      if (gap_len != 0 && e == gap_at + gap_len) en = 1'b1;
    end
    en    = 1'b1;
    start = 1'b0;
    check("lat_k0", 32'(e), 32'(ref_lat(16, b, gap_at, gap_len)));
    check("lat_k4", 32'(e4), 32'(ref_lat(12, b, gap_at, gap_len)));
    check("q_k0", 32'(q0), 32'(ref_q(a, b, 0)));
    check("r_k0", 32'(r0), 32'(ref_r(a, b, 0)));
    check("flags_k0", {29'd0, b0, d0, z0}, {29'd0, 1'b0, 1'b1, b == 8'd0});
    check("q_k4", 32'(q4), 32'(ref_q(a, b, 4)));
    check("r_k4", 32'(r4), 32'(ref_r(a, b, 4)));
    check("flags_k4", {29'd0, b4, d4, z4}, {29'd0, 1'b0, 1'b1, b == 8'd0});
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    int          g_at;
    int          g_len;

    rst_n    = 1'b0;
    en       = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset state
    #12;
    check("reset_k0", {q0, r0, 5'd0, b0, d0, z0}, 32'd0);
    check("reset_k4", {q4, r4, 5'd0, b4, d4, z4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(16'd1000,  8'd7,   0, 0, 0);
    run_op(16'd65535, 8'd255, 0, 0, 0);
    run_op(16'd0,     8'd9,   0, 0, 0);
    run_op(16'd500,   8'd0,   0, 0, 0);
    run_op(16'd1000,  8'd7,   9, 5, 0);
    run_op(16'd1000,  8'd7,   0, 0, 5);

    // Reset mid-run with the clock gated off
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    en    = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_k0", {q0, r0, 5'd0, b0, d0, z0}, 32'd0);
    check("midrst_k4", {q4, r4, 5'd0, b4, d4, z4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {29'd0, b0, d0, z0}, 32'd0);

    // Randomized operations with random en gaps
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      g_len = int'($urandom_range(0, 4));
      g_at  = int'($urandom_range(2, 15));
      run_op(ra, rb, g_at, g_len, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_gated_seq_div_16by8.md
Name: clock_gated_seq_div_16by8

Overview:
- Clock-gated sequential restoring divider. It is the inverse-direction companion to the team's clock-gated 8-bit approximate multiplier.
- Divides a 16-bit dividend by an 8-bit divisor at one quotient bit per gated clock, using a start/busy/done handshake.
- Optional approximation: the lowest APPROX_K quotient iterations are skipped.
- Sits beside the multiplier in the arithmetic datapath and shares its enable-driven clock-gating scheme for power comparison.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width.
- DIVISOR_W, 8, divisor and remainder width.
- APPROX_K, 0, number of low quotient bits not computed. Legal range 0..DIVIDEND_W-1. 0 gives an exact result.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  clock-gate enable. When low, all state and outputs freeze.
- start  input  1  request a new division. Sampled on a gated edge.
- dividend  input  DIVIDEND_W  numerator. Captured when start is accepted.
- divisor  input  DIVISOR_W  denominator. Captured when start is accepted.
- quotient  output  DIVIDEND_W  result quotient.
- remainder  output  DIVISOR_W  result remainder.
- busy  output  1  division in progress.
- done  output  1  result valid. Held until the next accepted start.
- div_by_zero  output  1  last accepted operation had divisor==0.

Behaviour:
- Clock gating:
  - gclk = clk AND en_lat, where en_lat comes from a latch transparent while clk is low (ICG style, glitch-free).
  - Every flop is clocked by gclk.
  - "Edge" below means a gclk rising edge.
- Reset:
  - rst_n low immediately clears all outputs and internal state to 0 and sets the FSM to IDLE.
  - This holds regardless of en or clk, including mid-operation.
- FSM states: IDLE, RUN, DONE. Let ITER = DIVIDEND_W - APPROX_K.
- IDLE or DONE with start=1 at an edge (accept), divisor != 0:
  - Load the dividend shift register and divisor, clear the partial remainder, set count = ITER.
  - busy=1, done=0, div_by_zero=0. Go to RUN.
- IDLE or DONE with start=1 at an edge (accept), divisor == 0:
  - quotient = all ones, remainder = dividend[DIVISOR_W-1:0], div_by_zero=1, done=1, busy=0. Go to DONE.
  - Latency is 1 edge.
- RUN, each edge, one iteration:
  - Shift the next dividend MSB into the (DIVISOR_W+1)-bit partial remainder.
  - Trial-subtract the divisor.
  - If the difference is non-negative, keep it and shift a 1 into the quotient. Otherwise shift a 0.
  - Decrement count.
- RUN, on the edge performing the last iteration (count 1 -> 0):
  - quotient/remainder outputs update.
  - busy=0, done=1, go to DONE.
  - Total latency: ITER edges after the accept edge.
- Approximate result: quotient = ((dividend >> APPROX_K) / divisor) << APPROX_K, remainder = (dividend >> APPROX_K) % divisor. The low APPROX_K quotient bits are 0.
- Output stability: quotient and remainder change only at completion, on a div-by-zero accept, or at reset. Otherwise they hold their previous value.
- Ignored inputs:
  - start during RUN is ignored: no restart, no corruption.
  - Operand changes after acceptance are ignored.
- en=0: no edges occur. The FSM, count and outputs freeze. Operation resumes unchanged when en returns to 1.
- An accepting start in DONE drops done on that same edge.

Test Plan:
- 1000/7, APPROX_K=0, en=1 -> busy for 16 edges. After edge 16: quotient=142, remainder=6, done=1, div_by_zero=0.
- 65535/255 -> quotient=257, remainder=0. Then 0/9 -> quotient=0, remainder=0. Back-to-back starts are issued from DONE.
- 500/0 -> one edge after accept: quotient=0xFFFF, remainder=0xF4, div_by_zero=1, done=1, busy=0.
- 1000/7 with en=0 for 5 clocks after iteration 8:
  - Outputs and busy are frozen during the gap.
  - done rises 21 clk cycles after accept.
  - Result is identical (142, 6).
- start pulsed with 200/3 during the 1000/7 run -> ignored, result 142/6. Then rst_n low mid-run -> all outputs 0 immediately, FSM IDLE.
- APPROX_K=4, 1000/7 -> done after 12 edges: quotient=128, remainder=6.
